spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  SPI controller (initiator) for the team's SPI peripheral command protocol; drives sck/ss/mosi, samples miso.
//  Frame: byte0 = {rw, addr[6:0]} (rw=1 READ, 0 WRITE); byte1 = wdata; READ adds byte2 clocked in from miso.
//  Sits between on-chip logic (start/done handshake) and the pins of an external or on-board SPI peripheral.
//  Mode 0, MSB first: sck idles low, mosi changes after falling sck, miso sampled on rising sck.
// PARAMETERS
//  CLK_DIV   4   clk cycles per sck half-period; legal >= 2 (elaboration assertion)
// PORTS
//  clk     in   1  system clock; all logic on posedge
//  rst     in   1  reset, asynchronous, active-low
//  start   in   1  request; accepted only on a clk edge where busy=0
//  rw      in   1  1=READ, 0=WRITE; sampled with start
//  addr    in   7  register address; sampled with start
//  wdata   in   8  byte1 payload (write data; ignored by peripheral on READ); sampled with start
//  busy    out  1  high from accept until transfer ends
//  done    out  1  1-cycle pulse at transfer end
//  rdata   out  8  byte2 received on READ; holds value until next READ completes
//  sck     out  1  SPI clock
//  ss      out  1  slave select, active-low
//  mosi    out  1  controller data out
//  miso    in   1  peripheral data in; Z while ss=1
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; sck=0, ss=1, mosi=0, busy=0, done=0, rdata=8'h00, all counters 0.
//  Accept: start=1 & busy=0 at edge T -> latch {rw,addr,wdata} into shift-out/context regs;
//   ss=0, busy=1, mosi=bit7 of byte0 from T+1.
//  FSM: IDLE -> SETUP (CLK_DIV cycles, sck=0) -> SHIFT (8 bits) -> GAP (CLK_DIV cycles, sck=0, ss=0)
//   -> SHIFT ... -> after last byte TEARDOWN (CLK_DIV cycles, ss=0) -> END (1 cycle) -> IDLE.
//   Byte count: WRITE 2, READ 3; GAP only between bytes (WRITE 1 gap, READ 2 gaps).
//  SHIFT: each bit = CLK_DIV cycles sck=0 then CLK_DIV cycles sck=1; rising edge samples miso into shift-in;
//   falling edge advances mosi to next bit; first bit of each byte driven on entry to SETUP/GAP.
//  Bit counter 3 bits (7 downto 0), byte counter 2 bits; half-period counter $clog2(CLK_DIV) bits, wraps at CLK_DIV-1.
//  Byte2 (READ): mosi driven 0 for all 8 bits.
//  END cycle: ss=1, sck=0, mosi=0, done=1, busy=0; on READ rdata<=shift-in in the same edge.
//  Latency: END cycle = T+1+35*CLK_DIV (WRITE), T+1+52*CLK_DIV (READ).
//  start while busy=1: ignored, no queueing, in-flight inputs not re-sampled.
//  start during END cycle: accepted (busy=0 there); ss stays high exactly 1 cycle (END) between frames.
//  rw/addr/wdata changes after accept: no effect.
//  Reset mid-transfer: ss=1, sck=0 immediately (async); no done pulse; rdata -> 8'h00.
//  miso X/Z outside READ byte2: never captured into rdata.
// STRUCTURE
//  Package spi_pkg: typedef enum {IDLE,SETUP,SHIFT,GAP,TEARDOWN,END} spi_m_state_t;
//   typedef enum logic {SPI_WRITE=1'b0, SPI_READ=1'b1} spi_op_t; localparams SPI_BYTES_WR=2, SPI_BYTES_RD=3.
//  Sub-module spi_clkgen: half-period counter; outputs sck, rise_stb, fall_stb; enabled only in SHIFT.
//  Top: FSM, bit/byte counters, 8-bit shift-out and shift-in registers, rdata register.
// TESTING (CLK_DIV=4 unless noted)
//  1 WRITE rw=0 addr=7'h15 wdata=8'hA5 -> mosi bytes 8'h15,8'hA5 at sck rises; done at T+141; busy 140 cycles.
//  2 READ rw=1 addr=7'h22, peripheral model returns 8'h3C -> mosi 8'hA2,wdata,8'h00; rdata=8'h3C at T+209.
//  3 start pulsed again mid-WRITE with addr=7'h7F -> ignored; only one frame on pins, one done.
//  4 rst=0 at bit 3 of byte1 -> ss=1,sck=0 same cycle; no done; rdata=8'h00; next WRITE completes normally.
//  5 start held high continuously, WRITE -> back-to-back frames, ss high exactly 1 cycle between, done each frame.
//  6 CLK_DIV=2 READ with model returning 8'hFF then 8'h01 -> rdata 8'hFF then 8'h01; done at T+105.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI command-protocol controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        TEARDOWN,
        END
    } spi_m_state_t;

    typedef enum logic {
        SPI_WRITE = 1'b0,
        SPI_READ  = 1'b1
    } spi_op_t;

    localparam int unsigned SPI_BYTES_WR = 2;
    localparam int unsigned SPI_BYTES_RD = 3;

endpackage

// File: rtl/spi_clkgen.sv
// SCK generator: half-period counter that toggles sck while enabled and flags the
// clk cycle on which sck rises or falls.
module spi_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_wrap;

    assign w_wrap = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Strobes mark the clk edge on which sck changes, so the sample sees pre-edge miso.
    assign o_rise_stb = w_wrap && !r_sck;
    assign o_fall_stb = w_wrap && r_sck;
    assign o_sck      = r_sck;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator for the {rw,addr} / wdata / rdata command frame, with a
// start/done handshake towards on-chip logic.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_sck,
    output logic       o_ss,
    output logic       o_mosi,
    input  logic       i_miso
);

    if (CLK_DIV < 2) begin : g_clk_div_check
        $error("spi_master: CLK_DIV must be at least 2");
    end

    localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    spi_m_state_t  r_state, w_state_next;
    spi_op_t       r_op;
    logic [CW-1:0] r_wait_cnt;
    logic [2:0]    r_bit_cnt;
    logic [1:0]    r_byte_cnt;
    logic [7:0]    r_shift_out, r_shift_in, r_wdata, r_rdata;
    logic          w_idle, w_accept, w_waiting, w_wait_done, w_last_byte, w_byte_end;
    logic          w_shift, w_sck, w_rise, w_fall;

    assign w_idle      = (r_state == IDLE) || (r_state == END);
    assign w_accept    = i_start && w_idle;
    assign w_shift     = (r_state == SHIFT);
    assign w_waiting   = (r_state == SETUP) || (r_state == GAP) || (r_state == TEARDOWN);
    assign w_wait_done = w_waiting && (r_wait_cnt == LAST);
    assign w_byte_end  = w_fall && (r_bit_cnt == 3'd0);
    assign w_last_byte = (r_op == SPI_READ) ? (r_byte_cnt == 2'(SPI_BYTES_RD - 1))
                                            : (r_byte_cnt == 2'(SPI_BYTES_WR - 1));

    spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (w_shift),
        .o_sck      (w_sck),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_state_next = SETUP;
            SETUP:    if (w_wait_done) w_state_next = SHIFT;
            SHIFT:    if (w_byte_end) w_state_next = w_last_byte ? TEARDOWN : GAP;
            GAP:      if (w_wait_done) w_state_next = SHIFT;
            TEARDOWN: if (w_wait_done) w_state_next = END;
            END:      w_state_next = w_accept ? SETUP : IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_shift_out <= '0;
            r_shift_in  <= '0;
            r_wdata     <= '0;
            r_op        <= SPI_WRITE;
            r_rdata     <= '0;
        end else begin
            if (w_waiting) begin
                r_wait_cnt <= w_wait_done ? '0 : r_wait_cnt + CW'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            // Next byte is preloaded on the last fall so its MSB sits on mosi through GAP.
            if (w_accept) begin
                r_shift_out <= {i_rw, i_addr};
                r_wdata     <= i_wdata;
                r_op        <= spi_op_t'(i_rw);
                r_byte_cnt  <= '0;
            end else if (w_byte_end) begin
                r_shift_out <= (r_byte_cnt == 2'd0) ? r_wdata : 8'h00;
                r_byte_cnt  <= r_byte_cnt + 2'd1;
            end else if (w_fall) begin
                r_shift_out <= {r_shift_out[6:0], 1'b0};
            end

            if ((r_state == SETUP || r_state == GAP) && w_wait_done) begin
                r_bit_cnt <= 3'd7;
            end else if (w_fall && r_bit_cnt != 3'd0) begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
            end

            // Only byte2 of a READ is captured, so undriven miso never reaches rdata.
            if (w_rise && r_op == SPI_READ && r_byte_cnt == 2'd2) begin
                r_shift_in <= {r_shift_in[6:0], i_miso};
            end

            if (r_state == TEARDOWN && w_wait_done && r_op == SPI_READ) begin
                r_rdata <= r_shift_in;
            end
        end
    end

    assign o_busy  = !w_idle;
    assign o_ss    = w_idle;
    assign o_done  = (r_state == END);
    assign o_mosi  = w_idle ? 1'b0 : r_shift_out[7];
    assign o_sck   = w_sck;
    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master (CLK_DIV=4 instance plus a CLK_DIV=2 instance).
module tb_spi_master;

    logic       clk;
    logic       rst_n;
    logic       start, rw, busy, done, sck, ss, mosi, miso;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;
    logic       start2, rw2, busy2, done2, sck2, ss2, mosi2, miso2;
    logic [6:0] addr2;
    logic [7:0] wdata2, rdata2;

    int n_checks = 0;
    int n_fail   = 0;

    spi_master #(.CLK_DIV(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rw(rw), .i_addr(addr),
        .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_sck(sck),
        .o_ss(ss), .o_mosi(mosi), .i_miso(miso)
    );

    spi_master #(.CLK_DIV(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_rw(rw2), .i_addr(addr2),
        .i_wdata(wdata2), .o_busy(busy2), .o_done(done2), .o_rdata(rdata2), .o_sck(sck2),
        .o_ss(ss2), .o_mosi(mosi2), .i_miso(miso2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Peripheral model: drives the response byte during byte2, changing after falling sck.
    logic [7:0] resp, resp2;
    int         fall_cnt, fall_cnt2;
    always @(negedge sck or posedge ss) begin
        if (ss) fall_cnt <= 0;
        else    fall_cnt <= fall_cnt + 1;
    end
    always @(negedge sck2 or posedge ss2) begin
        if (ss2) fall_cnt2 <= 0;
        else     fall_cnt2 <= fall_cnt2 + 1;
    end
    assign miso  = (fall_cnt >= 16 && fall_cnt < 24) ? resp[3'(23 - fall_cnt)] : 1'b1;
    assign miso2 = (fall_cnt2 >= 16 && fall_cnt2 < 24) ? resp2[3'(23 - fall_cnt2)] : 1'b1;

    // Pin monitor for the CLK_DIV=4 instance.
    logic [23:0] cap;
    int          rise_cnt;
    int          frames;
    int          done_cnt;
    always @(posedge sck or negedge ss) begin
        if (!sck) begin
            cap      <= '0;
            rise_cnt <= 0;
        end else begin
            cap      <= {cap[22:0], mosi};
            rise_cnt <= rise_cnt + 1;
        end
    end
    always @(negedge ss) frames <= frames + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                             output int done_k, output int busy_n, output logic [2:0] first);
        int k;
        @(negedge clk);
        start = 1'b1; rw = r; addr = a; wdata = d;
        @(negedge clk);
        start = 1'b0;
        first = {ss, busy, mosi};
        k = 1;
        busy_n = 0;
        while (!done && k < 400) begin
            if (busy) busy_n++;
            @(negedge clk);
            k++;
        end
        done_k = done ? k : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sck, ss, mosi, busy, done} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_pins: got sck,ss,mosi,busy,done=%b expected 01000",
                     {sck, ss, mosi, busy, done});
        end
        n_checks++;
        if (rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata);
        end
        n_checks++;
        if ({sck2, ss2, busy2, done2, rdata2} !== {4'b0100, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_dut2: got %b expected 010000000000",
                     {sck2, ss2, busy2, done2, rdata2});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ss, busy} !== 2'b10) begin
            n_fail++; $display("FAIL reset_idle: got ss,busy=%b expected 10", {ss, busy});
        end
    endtask

    task automatic test_write();
        int dk, bn;
        logic [2:0] f;
        run_frame(1'b0, 7'h15, 8'hA5, dk, bn, f);
        n_checks++;
        if (f !== 3'b010) begin
            n_fail++; $display("FAIL wr_accept: got ss,busy,mosi=%b expected 010", f);
        end
        n_checks++;
        if (dk !== 141) begin
            n_fail++; $display("FAIL wr_done_latency: got %0d expected 141", dk);
        end
        n_checks++;
        if (bn !== 140) begin
            n_fail++; $display("FAIL wr_busy_cycles: got %0d expected 140", bn);
        end
        n_checks++;
        if (cap[15:0] !== 16'h15A5 || rise_cnt !== 16) begin
            n_fail++;
            $display("FAIL wr_mosi: got %h/%0d rises expected 15a5/16", cap[15:0], rise_cnt);
        end
        n_checks++;
        if ({ss, sck, mosi, busy} !== 4'b1000) begin
            n_fail++; $display("FAIL wr_end_pins: got ss,sck,mosi,busy=%b expected 1000",
                               {ss, sck, mosi, busy});
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL wr_done_pulse: got done=%b expected 0", done);
        end
    endtask

    task automatic test_read();
        int dk, bn;
        logic [2:0] f;
        resp = 8'h3C;
        run_frame(1'b1, 7'h22, 8'h5A, dk, bn, f);
        n_checks++;
        if (f !== 3'b011) begin
            n_fail++; $display("FAIL rd_accept: got ss,busy,mosi=%b expected 011", f);
        end
        n_checks++;
        if (dk !== 209 || bn !== 208) begin
            n_fail++; $display("FAIL rd_latency: got done %0d busy %0d expected 209/208", dk, bn);
        end
        n_checks++;
        if (cap !== 24'hA25A00 || rise_cnt !== 24) begin
            n_fail++; $display("FAIL rd_mosi: got %h/%0d expected a25a00/24", cap, rise_cnt);
        end
        n_checks++;
        if (rdata !== 8'h3C) begin
            n_fail++; $display("FAIL rd_rdata: got %h expected 3c", rdata);
        end
    endtask

    task automatic test_start_while_busy();
        int k, d0, f0;
        @(negedge clk);
        d0 = done_cnt;
        f0 = frames;
        start = 1'b1; rw = 1'b0; addr = 7'h10; wdata = 8'h33;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 400) begin
            if (k == 60) begin
                start = 1'b1; rw = 1'b1; addr = 7'h7F; wdata = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        n_checks++;
        if (k !== 141 || cap[15:0] !== 16'h1033 || rise_cnt !== 16) begin
            n_fail++;
            $display("FAIL busy_ignore_frame: got done %0d mosi %h/%0d expected 141 1033/16",
                     k, cap[15:0], rise_cnt);
        end
        repeat (300) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 1 || frames - f0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore_count: got dones %0d frames %0d busy %b expected 1 1 0",
                     done_cnt - d0, frames - f0, busy);
        end
        n_checks++;
        if (rdata !== 8'h3C) begin
            n_fail++; $display("FAIL rdata_hold: got %h expected 3c", rdata);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int k, d0, dk, bn;
        logic [2:0] f;
        @(negedge clk);
        d0 = done_cnt;
        start = 1'b1; rw = 1'b0; addr = 7'h44; wdata = 8'h99;
        @(negedge clk);
        start = 1'b0;
        for (k = 1; k < 110; k++) @(negedge clk);
        // Cycle 110 is the high half of byte1 bit 3.
        n_checks++;
        if ({ss, sck} !== 2'b01) begin
            n_fail++; $display("FAIL mid_pre_reset: got ss,sck=%b expected 01", {ss, sck});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ss, sck, busy, rdata} !== {3'b100, 8'h00}) begin
            n_fail++; $display("FAIL mid_reset_async: got ss,sck,busy,rdata=%b expected 10000000000",
                               {ss, sck, busy, rdata});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt !== d0) begin
            n_fail++; $display("FAIL mid_no_done: got %0d dones expected %0d", done_cnt, d0);
        end
        run_frame(1'b0, 7'h2A, 8'h0F, dk, bn, f);
        n_checks++;
        if (dk !== 141 || cap[15:0] !== 16'h2A0F) begin
            n_fail++; $display("FAIL mid_recover: got done %0d mosi %h expected 141 2a0f",
                               dk, cap[15:0]);
        end
    endtask

    task automatic test_back_to_back();
        int k, run, nruns, max_run, n_done;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 7'h05; wdata = 8'hC3;
        @(negedge clk);
        k = 1; run = 0; nruns = 0; max_run = 0; n_done = 0;
        while (k < 423) begin
            @(negedge clk);
            k++;
            if (done) n_done++;
            if (ss) begin
                run++;
            end else if (run > 0) begin
                nruns++;
                if (run > max_run) max_run = run;
                run = 0;
            end
        end
        n_checks++;
        if (done !== 1'b1 || n_done !== 3) begin
            n_fail++; $display("FAIL b2b_dones: got %0d (done now %b) expected 3 (1)", n_done, done);
        end
        n_checks++;
        if (nruns !== 2 || max_run !== 1) begin
            n_fail++; $display("FAIL b2b_ss_gap: got %0d gaps max %0d expected 2 gaps max 1",
                               nruns, max_run);
        end
        n_checks++;
        if (cap[15:0] !== 16'h05C3 || rise_cnt !== 16) begin
            n_fail++; $display("FAIL b2b_mosi: got %h/%0d expected 05c3/16", cap[15:0], rise_cnt);
        end
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ss, busy} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_stop: got ss,busy=%b expected 10", {ss, busy});
        end
    endtask

    task automatic test_clk_div2();
        logic [7:0] resps [2];
        int k;
        resps[0] = 8'hFF;
        resps[1] = 8'h01;
        for (int i = 0; i < 2; i++) begin
            resp2 = resps[i];
            @(negedge clk);
            start2 = 1'b1; rw2 = 1'b1; addr2 = 7'h31; wdata2 = 8'h77;
            @(negedge clk);
            start2 = 1'b0;
            k = 1;
            while (!done2 && k < 200) begin
                @(negedge clk);
                k++;
            end
            n_checks++;
            if (k !== 105) begin
                n_fail++; $display("FAIL div2_latency: got %0d expected 105", k);
            end
            n_checks++;
            if (rdata2 !== resps[i]) begin
                n_fail++; $display("FAIL div2_rdata: got %h expected %h", rdata2, resps[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; resp = 8'h00;
        start2 = 1'b0; rw2 = 1'b0; addr2 = '0; wdata2 = '0; resp2 = 8'h00;
        frames = 0;
        done_cnt = 0;
        test_reset();
        test_write();
        test_read();
        test_start_while_busy();
        test_reset_mid_transfer();
        test_back_to_back();
        test_clk_div2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
